// File: rtl/trdb_tb_pkg.sv
// Shared types and record layout helpers for the trace debugger bench player.
package trdb_tb_pkg;

  typedef enum logic [1:0] {StIdle, StGap, StPlay, StDone} state_e;

  localparam int unsigned GapW   = 8;
  localparam int unsigned CauseW = 5;
  localparam int unsigned HdrW   = GapW + CauseW;

  // Upper fields of a retire record; the per-channel payload sits below them.
  typedef struct packed {
    logic [GapW-1:0]   gap;
    logic [CauseW-1:0] cause;
  } rec_hdr_t;

  function automatic int unsigned rec_w(int unsigned nret, int unsigned xlen, int unsigned ilen);
    return HdrW + nret * (2 + xlen + ilen);
  endfunction

endpackage

// File: rtl/trdb_tb_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) used for random sink backpressure.
// Only compiled when TRDB_TB_BACKPRESSURE_EN is defined.
`ifdef TRDB_TB_BACKPRESSURE_EN
module trdb_tb_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  output logic [15:0] state_o
);

  logic [15:0] lfsr_q, lfsr_d;
  logic        fb;

  always_comb begin
    fb     = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    lfsr_d = en_i ? {fb, lfsr_q[15:1]} : lfsr_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o = lfsr_q;

endmodule
`endif

// File: rtl/trdb_tb_player.sv
// Bench-side retire record player and trace packet sink.
// TRDB_TB_BACKPRESSURE_EN: drive packet_ready_o from an LFSR instead of tying it high.
module trdb_tb_player
  import trdb_tb_pkg::*;
#(
  parameter int unsigned NRET  = 1,
  parameter int unsigned XLEN  = 32,
  parameter int unsigned ILEN  = 32,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned PKT_W = 128,
  parameter int unsigned CNT_W = 16,
  localparam int unsigned REC_W = rec_w(NRET, XLEN, ILEN)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load_valid_i,
  output logic                 load_ready_o,
  input  logic [REC_W-1:0]     load_rec_i,
  input  logic                 clear_i,
  input  logic                 start_i,
  input  logic                 stop_i,
  output logic [NRET-1:0]      ivalid_o,
  output logic [NRET-1:0]      iexception_o,
  output logic [CauseW-1:0]    cause_o,
  output logic [NRET*XLEN-1:0] iaddr_o,
  output logic [NRET*ILEN-1:0] insn_o,
  input  logic                 packet_valid_i,
  output logic                 packet_ready_o,
  input  logic [PKT_W-1:0]     packet_i,
  output logic [PKT_W-1:0]     last_packet_o,
  output logic [CNT_W-1:0]     pkt_cnt_o,
  output logic                 overflow_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam int unsigned AddrLsb  = NRET * ILEN;
  localparam int unsigned ExcLsb   = AddrLsb + NRET * XLEN;
  localparam int unsigned VmaskLsb = ExcLsb + NRET;

  logic [REC_W-1:0] mem_q [DEPTH];
  logic [AW:0]      count_q, count_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d, rd_idx;
  logic [GapW-1:0]  gap_q, gap_d;
  state_e           state_q, state_d;
  logic [REC_W-1:0] rd_rec;
  rec_hdr_t         rd_hdr;
  logic             play, cnt_clr, buf_clr, ld_fire, pkt_fire;

  logic [NRET-1:0]      ivalid_q, iexc_q;
  logic [CauseW-1:0]    cause_q;
  logic [NRET*XLEN-1:0] iaddr_q;
  logic [NRET*ILEN-1:0] insn_q;
  logic [PKT_W-1:0]     last_packet_q;
  logic [CNT_W-1:0]     pkt_cnt_q;
  logic                 overflow_q;

  // Record looked at this cycle: the one about to play, or the first after start.
  always_comb begin
    rd_idx = '0;
    unique case (state_q)
      StGap:   rd_idx = rd_ptr_q;
      StPlay:  rd_idx = rd_ptr_q + AW'(1);
      default: rd_idx = '0;
    endcase
  end

  assign rd_rec = mem_q[rd_idx];
  assign rd_hdr = rec_hdr_t'(rd_rec[REC_W-1 -: HdrW]);

  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    gap_d    = gap_q;
    play     = 1'b0;
    cnt_clr  = 1'b0;
    buf_clr  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (clear_i) begin
          buf_clr = 1'b1;
        end else if (start_i) begin
          cnt_clr  = 1'b1;
          rd_ptr_d = '0;
          if (count_q == '0) begin
            state_d = StDone;
          end else if (rd_hdr.gap == '0) begin
            state_d = StPlay;
            play    = 1'b1;
          end else begin
            state_d = StGap;
            gap_d   = rd_hdr.gap - 8'd1;
          end
        end
      end
      StGap: begin
        if (stop_i) begin
          state_d = StIdle;
        end else if (gap_q == '0) begin
          state_d = StPlay;
          play    = 1'b1;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      StPlay: begin
        if (stop_i) begin
          state_d = StIdle;
        end else if (({1'b0, rd_ptr_q} + (AW+1)'(1)) == count_q) begin
          state_d = StDone;
        end else begin
          rd_ptr_d = rd_idx;
          if (rd_hdr.gap == '0) begin
            play = 1'b1;
          end else begin
            state_d = StGap;
            gap_d   = rd_hdr.gap - 8'd1;
          end
        end
      end
      StDone: begin
        if (clear_i) begin
          buf_clr = 1'b1;
          state_d = StIdle;
        end else if (start_i) begin
          cnt_clr = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign load_ready_o = (state_q == StIdle) && !count_q[AW];
  assign ld_fire      = load_valid_i && load_ready_o && !buf_clr;

  always_comb begin
    count_d = count_q;
    if (buf_clr) begin
      count_d = '0;
    end else if (ld_fire) begin
      count_d = count_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (ld_fire) begin
      mem_q[count_q[AW-1:0]] <= load_rec_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      count_q  <= '0;
      rd_ptr_q <= '0;
      gap_q    <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      gap_q    <= gap_d;
    end
  end

  // Address and instruction hold their last played values between plays.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ivalid_q <= '0;
      iexc_q   <= '0;
      cause_q  <= '0;
      iaddr_q  <= '0;
      insn_q   <= '0;
    end else if (play) begin
      ivalid_q <= rd_rec[VmaskLsb +: NRET];
      iexc_q   <= rd_rec[ExcLsb +: NRET];
      cause_q  <= rd_hdr.cause;
      iaddr_q  <= rd_rec[AddrLsb +: NRET*XLEN];
      insn_q   <= rd_rec[0 +: NRET*ILEN];
    end else begin
      ivalid_q <= '0;
      iexc_q   <= '0;
      cause_q  <= '0;
    end
  end

`ifdef TRDB_TB_BACKPRESSURE_EN
  logic [15:0] lfsr_state;

  trdb_tb_lfsr #(
    .SEED(16'hACE1)
  ) u_lfsr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (1'b1),
    .state_o(lfsr_state)
  );

  assign packet_ready_o = lfsr_state[0];
`else
  assign packet_ready_o = 1'b1;
`endif

  assign pkt_fire = packet_valid_i && packet_ready_o;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      last_packet_q <= '0;
      pkt_cnt_q     <= '0;
      overflow_q    <= 1'b0;
    end else begin
      if (pkt_fire) begin
        last_packet_q <= packet_i;
      end
      if (cnt_clr) begin
        pkt_cnt_q  <= '0;
        overflow_q <= 1'b0;
      end else if (pkt_fire) begin
        if (&pkt_cnt_q) begin
          overflow_q <= 1'b1;
        end else begin
          pkt_cnt_q <= pkt_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign ivalid_o      = ivalid_q;
  assign iexception_o  = iexc_q;
  assign cause_o       = cause_q;
  assign iaddr_o       = iaddr_q;
  assign insn_o        = insn_q;
  assign last_packet_o = last_packet_q;
  assign pkt_cnt_o     = pkt_cnt_q;
  assign overflow_o    = overflow_q;
  assign busy_o        = (state_q == StGap) || (state_q == StPlay);
  assign done_o        = (state_q == StDone);

endmodule

// File: tb/tb_trdb_tb_player.sv
// Self-checking bench for trdb_tb_player: directed tables, corner sequences and random replays.
module tb_trdb_tb_player;
  import trdb_tb_pkg::*;

  localparam int unsigned NRET  = 2;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned ILEN  = 32;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned PKT_W = 32;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned REC_W = rec_w(NRET, XLEN, ILEN);
  localparam int MaxCnt = 15;

  typedef struct packed {
    logic [7:0]  gap;
    logic [4:0]  cause;
    logic [1:0]  vmask;
    logic [1:0]  exc;
    logic [63:0] addr;
    logic [63:0] insn;
  } rec_t;

  typedef struct {
    rec_t       rec;
    logic [1:0] ev;
    logic [1:0] ee;
    logic [4:0] ec;
    int         delay;
  } vec_t;

  logic                 clk, rst_n;
  logic                 load_valid, load_ready, clear, start, stop;
  logic [REC_W-1:0]     load_rec;
  logic [NRET-1:0]      ivalid, iexc;
  logic [4:0]           cause;
  logic [NRET*XLEN-1:0] iaddr;
  logic [NRET*ILEN-1:0] insn;
  logic                 packet_valid, packet_ready;
  logic [PKT_W-1:0]     packet, last_packet;
  logic [CNT_W-1:0]     pkt_cnt;
  logic                 overflow, busy, done;

  trdb_tb_player #(
    .NRET (NRET),
    .XLEN (XLEN),
    .ILEN (ILEN),
    .DEPTH(DEPTH),
    .PKT_W(PKT_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .load_valid_i  (load_valid),
    .load_ready_o  (load_ready),
    .load_rec_i    (load_rec),
    .clear_i       (clear),
    .start_i       (start),
    .stop_i        (stop),
    .ivalid_o      (ivalid),
    .iexception_o  (iexc),
    .cause_o       (cause),
    .iaddr_o       (iaddr),
    .insn_o        (insn),
    .packet_valid_i(packet_valid),
    .packet_ready_o(packet_ready),
    .packet_i      (packet),
    .last_packet_o (last_packet),
    .pkt_cnt_o     (pkt_cnt),
    .overflow_o    (overflow),
    .busy_o        (busy),
    .done_o        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  rec_t        bufq[$];
  int          obs[$];
  logic [63:0] exp_addr = '0;
  logic [63:0] exp_insn = '0;
  logic [31:0] exp_last = '0;
  int          exp_cnt = 0;
  logic        exp_ovf = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_buf();
    clear = 1'b1;
    tick();
    tick();
    clear = 1'b0;
    bufq.delete();
  endtask

  task automatic load(input rec_t r);
    chk("load_ready", load_ready, bufq.size() < DEPTH);
    load_valid = 1'b1;
    load_rec   = r;
    tick();
    load_valid = 1'b0;
    if (bufq.size() < DEPTH) bufq.push_back(r);
  endtask

  function automatic rec_t rand_rec(input int max_gap);
    rec_t r;
    r.gap   = 8'($urandom_range(0, max_gap));
    r.cause = 5'($urandom);
    r.vmask = 2'($urandom_range(1, 3));
    r.exc   = 2'($urandom) & r.vmask;
    r.addr  = {$urandom, $urandom};
    r.insn  = {$urandom, $urandom};
    return r;
  endfunction

  // Record r plays at sum over i<=r of (gap(i)+1) cycles after start is sampled.
  task automatic replay_check(input string tag, output int done_at);
    int t[$];
    int acc;
    int last;
    acc = 0;
    foreach (bufq[r]) begin
      acc += int'(bufq[r].gap) + 1;
      t.push_back(acc);
    end
    last    = acc;
    done_at = -1;
    obs.delete();
    start = 1'b1;
    tick();
    start   = 1'b0;
    exp_cnt = 0;
    exp_ovf = 1'b0;
    for (int k = 1; k <= last + 2; k++) begin
      logic [1:0] ev, ee;
      logic [4:0] ec;
      ev = '0;
      ee = '0;
      ec = '0;
      foreach (t[r]) begin
        if (t[r] == k) begin
          ev       = bufq[r].vmask;
          ee       = bufq[r].exc;
          ec       = bufq[r].cause;
          exp_addr = bufq[r].addr;
          exp_insn = bufq[r].insn;
        end
      end
      chk($sformatf("%s ivalid k=%0d", tag, k), ivalid, ev);
      chk($sformatf("%s iexc k=%0d", tag, k), iexc, ee);
      chk($sformatf("%s cause k=%0d", tag, k), cause, ec);
      chk($sformatf("%s iaddr k=%0d", tag, k), iaddr, exp_addr);
      chk($sformatf("%s insn k=%0d", tag, k), insn, exp_insn);
      chk($sformatf("%s busy k=%0d", tag, k), busy, k <= last);
      chk($sformatf("%s done k=%0d", tag, k), done, k > last);
      if (ivalid != '0) obs.push_back(k);
      if (done && done_at < 0) done_at = k;
      if (k < last + 2) tick();
    end
  endtask

  task automatic send_packets(input int n);
    int got;
    int guard;
    logic rdy;
    logic [31:0] p;
    got   = 0;
    guard = 0;
    packet_valid = 1'b1;
    while (got < n && guard < 400) begin
      p      = $urandom;
      packet = p;
      rdy    = packet_ready;
      tick();
      if (rdy) begin
        got++;
        exp_last = p;
        if (exp_cnt == MaxCnt) exp_ovf = 1'b1;
        else exp_cnt++;
      end
      guard++;
    end
    packet_valid = 1'b0;
    chk("send_packets_accepted", got, n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    int   exp_t1[3];
    rec_t r9[9];
    int   done_at;

    vecs[0].rec = {8'd0, 5'd2, 2'b10, 2'b10, 64'h0000_0004_0000_1000, 64'h0000_0013_0000_0073};
    vecs[0].ev = 2'b10; vecs[0].ee = 2'b10; vecs[0].ec = 5'd2;  vecs[0].delay = 1;
    vecs[1].rec = {8'd3, 5'd0, 2'b11, 2'b00, 64'hDEAD_BEEF_0000_2000, 64'h1111_2222_3333_4444};
    vecs[1].ev = 2'b11; vecs[1].ee = 2'b00; vecs[1].ec = 5'd0;  vecs[1].delay = 4;
    vecs[2].rec = {8'd1, 5'd31, 2'b01, 2'b01, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF};
    vecs[2].ev = 2'b01; vecs[2].ee = 2'b01; vecs[2].ec = 5'd31; vecs[2].delay = 2;
    vecs[3].rec = {8'd7, 5'd7, 2'b11, 2'b01, 64'hA5A5_A5A5_5A5A_5A5A, 64'h0F0F_0F0F_F0F0_F0F0};
    vecs[3].ev = 2'b11; vecs[3].ee = 2'b01; vecs[3].ec = 5'd7;  vecs[3].delay = 8;
    vecs[4].rec = {8'd255, 5'd0, 2'b01, 2'b00, 64'h0000_0001_0000_0001, 64'h0000_0002_0000_0002};
    vecs[4].ev = 2'b01; vecs[4].ee = 2'b00; vecs[4].ec = 5'd0;  vecs[4].delay = 256;
    exp_t1[0] = 1; exp_t1[1] = 4; exp_t1[2] = 6;

    rst_n = 1'b0; load_valid = 1'b0; load_rec = '0; clear = 1'b0; start = 1'b0; stop = 1'b0;
    packet_valid = 1'b0; packet = '0;
    tick();
    tick();
    chk("rst load_ready", load_ready, 1);
    chk("rst packet_ready", packet_ready, 1);
    chk("rst ivalid", ivalid, 0);
    chk("rst iexc", iexc, 0);
    chk("rst cause", cause, 0);
    chk("rst iaddr", iaddr, 0);
    chk("rst insn", insn, 0);
    chk("rst last_packet", last_packet, 0);
    chk("rst pkt_cnt", pkt_cnt, 0);
    chk("rst overflow", overflow, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    rst_n = 1'b1;
    tick();

    // Three records with gaps {0,2,1}: plays at +1,+4,+6, done at +7.
    for (int i = 0; i < 3; i++) begin
      rec_t r;
      r = rand_rec(0);
      r.gap = (i == 0) ? 8'd0 : (i == 1) ? 8'd2 : 8'd1;
      load(r);
    end
    replay_check("t1", done_at);
    chk("t1 play count", obs.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t1 play time %0d", i), (i < obs.size()) ? obs[i] : -1, exp_t1[i]);
    end
    chk("t1 done time", done_at, 7);

    // Single-record vectors.
    for (int i = 0; i < 5; i++) begin
      int d;
      clear_buf();
      load(vecs[i].rec);
      start = 1'b1;
      tick();
      start = 1'b0;
      d = 1;
      while (ivalid == '0 && d < 300) begin
        tick();
        d++;
      end
      chk($sformatf("vec%0d delay", i), d, vecs[i].delay);
      chk($sformatf("vec%0d ivalid", i), ivalid, vecs[i].ev);
      chk($sformatf("vec%0d iexc", i), iexc, vecs[i].ee);
      chk($sformatf("vec%0d cause", i), cause, vecs[i].ec);
      chk($sformatf("vec%0d iaddr", i), iaddr, vecs[i].rec.addr);
      chk($sformatf("vec%0d insn", i), insn, vecs[i].rec.insn);
      exp_addr = vecs[i].rec.addr;
      exp_insn = vecs[i].rec.insn;
      tick();
      chk($sformatf("vec%0d ivalid after", i), ivalid, 0);
      chk($sformatf("vec%0d iexc after", i), iexc, 0);
      chk($sformatf("vec%0d cause after", i), cause, 0);
      chk($sformatf("vec%0d done after", i), done, 1);
      chk($sformatf("vec%0d iaddr held", i), iaddr, vecs[i].rec.addr);
    end

    // Overfill: DEPTH+1 loads, the last is dropped.
    clear_buf();
    for (int i = 0; i < 9; i++) begin
      r9[i] = rand_rec(0);
      load(r9[i]);
    end
    chk("full load_ready", load_ready, 0);
    replay_check("full", done_at);
    chk("full play count", obs.size(), DEPTH);
    chk("full last iaddr", iaddr, r9[7].addr);
    chk("full done time", done_at, 9);

    // Stop during record 2's gap, then restart from record 0.
    clear_buf();
    for (int i = 0; i < 3; i++) begin
      rec_t r;
      r = rand_rec(0);
      r.gap = (i == 2) ? 8'd5 : 8'd0;
      load(r);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("stop rec0 ivalid", ivalid, bufq[0].vmask);
    tick();
    chk("stop rec1 ivalid", ivalid, bufq[1].vmask);
    chk("stop rec1 iaddr", iaddr, bufq[1].addr);
    exp_addr = bufq[1].addr;
    exp_insn = bufq[1].insn;
    tick();
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop busy", busy, 0);
    chk("stop done", done, 0);
    chk("stop ivalid", ivalid, 0);
    chk("stop idle load_ready", load_ready, 1);
    begin
      int spurious;
      spurious = 0;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (ivalid != '0 || busy) spurious++;
      end
      chk("stop no further plays", spurious, 0);
    end
    replay_check("restart", done_at);
    chk("restart first play", (obs.size() > 0) ? obs[0] : -1, 1);

    // Clear and load in the same cycle: clear wins, so start finds an empty buffer.
    clear_buf();
    load_valid = 1'b1;
    load_rec   = rand_rec(3);
    clear      = 1'b1;
    tick();
    load_valid = 1'b0;
    clear      = 1'b0;
    replay_check("clrload", done_at);
    chk("clrload done time", done_at, 1);

    // Random replays against the schedule model.
    for (int it = 0; it < 15; it++) begin
      int n;
      clear_buf();
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) load(rand_rec(4));
      replay_check($sformatf("rnd%0d", it), done_at);
    end

    // Saturating packet counter.
    send_packets(15);
    chk("cnt at 15", pkt_cnt, exp_cnt);
    chk("ovf at 15", overflow, exp_ovf);
    chk("cnt model 15", exp_cnt, MaxCnt);
    send_packets(2);
    chk("cnt at 17", pkt_cnt, 15);
    chk("ovf at 17", overflow, 1);
    chk("last packet", last_packet, exp_last);
    clear_buf();
    start = 1'b1;
    tick();
    start   = 1'b0;
    exp_cnt = 0;
    exp_ovf = 1'b0;
    chk("cnt after start", pkt_cnt, 0);
    chk("ovf after start", overflow, 0);

    // Long stream of distinct packets: none lost or duplicated.
    begin
      int acc;
      int bad;
      logic rdy;
      logic [31:0] p;
      acc = 0;
      bad = 0;
      packet_valid = 1'b1;
      for (int c = 0; c < 1000; c++) begin
        p      = 32'h1000_0000 + 32'(c);
        packet = p;
        rdy    = packet_ready;
        tick();
        if (rdy) begin
          acc++;
          exp_last = p;
          if (exp_cnt == MaxCnt) exp_ovf = 1'b1;
          else exp_cnt++;
        end
        if (last_packet !== exp_last) bad++;
      end
      packet_valid = 1'b0;
      chk("stream last_packet errors", bad, 0);
`ifdef TRDB_TB_BACKPRESSURE_EN
      chk("stream accept in 400..600", (acc >= 400) && (acc <= 600), 1);
`else
      chk("stream accept all", acc, 1000);
`endif
      chk("stream cnt", pkt_cnt, exp_cnt);
      chk("stream ovf", overflow, exp_ovf);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
